// File: rtl/park_scheduler_if.sv
// park_scheduler_if: gate request/response and lot status bundle for park_scheduler
interface park_scheduler_if;
  logic entry_req;
  logic exit_req;
  logic [2:0] exit_token;
  logic [2:0] pattern;
  logic entry_grant;
  logic [2:0] entry_token;
  logic entry_reject;
  logic exit_ack;
  logic [7:0] exit_location;
  logic exit_err;
  logic [7:0] occupied;
  logic [3:0] free_count;
  logic full;
  logic locked;
  modport master (
    output entry_req, exit_req, exit_token, pattern,
    input entry_grant, entry_token, entry_reject, exit_ack, exit_location, exit_err,
    input occupied, free_count, full, locked
  );
  modport slave (
    input entry_req, exit_req, exit_token, pattern,
    output entry_grant, entry_token, entry_reject, exit_ack, exit_location, exit_err,
    output occupied, free_count, full, locked
  );
endinterface

// File: rtl/park_scheduler.sv
// park_scheduler: 8-slot parking lot sequencer with token-encrypted entry/exit; PARK_LOCKOUT_EN adds exit lockout after repeated bad tokens
module park_scheduler #(
  parameter int N_SLOTS = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  park_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ALLOC, CHECK, HOLD} state_t;
  state_t state, state_nxt;
  logic [2:0] pat_q, tok_q, pat_nxt, tok_nxt;
  logic is_exit, is_exit_nxt;
  logic [7:0] occ_nxt, loc_nxt;
  logic [3:0] fc_nxt;
  logic grant_nxt, rej_nxt, ack_nxt, err_nxt;
  logic [2:0] etok_nxt, free_s, chk_s;
  logic found, chk_ok, lock_busy;
  always_comb begin
    found = 1'b0;
    free_s = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (i < N_SLOTS && !bus.occupied[i]) begin
        found = 1'b1;
        free_s = 3'(i);
      end
    chk_s = tok_q ^ pat_q;
    chk_ok = int'(chk_s) < N_SLOTS && bus.occupied[chk_s];
    state_nxt = state;
    pat_nxt = pat_q;
    tok_nxt = tok_q;
    is_exit_nxt = is_exit;
    occ_nxt = bus.occupied;
    fc_nxt = bus.free_count;
    grant_nxt = 1'b0;
    rej_nxt = 1'b0;
    ack_nxt = 1'b0;
    err_nxt = 1'b0;
    etok_nxt = 3'd0;
    loc_nxt = 8'd0;
    case (state)
      IDLE:
        if (bus.exit_req && !lock_busy) begin
          tok_nxt = bus.exit_token;
          pat_nxt = bus.pattern;
          is_exit_nxt = 1'b1;
          state_nxt = CHECK;
        end else if (bus.entry_req) begin
          pat_nxt = bus.pattern;
          is_exit_nxt = 1'b0;
          state_nxt = ALLOC;
        end
      ALLOC: begin
        if (found) begin
          occ_nxt[free_s] = 1'b1;
          fc_nxt = bus.free_count - 4'd1;
          grant_nxt = 1'b1;
          etok_nxt = free_s ^ pat_q;
        end else
          rej_nxt = 1'b1;
        state_nxt = HOLD;
      end
      CHECK: begin
        if (chk_ok) begin
          occ_nxt[chk_s] = 1'b0;
          fc_nxt = bus.free_count + 4'd1;
          ack_nxt = 1'b1;
          loc_nxt = 8'b1 << chk_s;
        end else
          err_nxt = 1'b1;
        state_nxt = HOLD;
      end
      default: state_nxt = (is_exit ? bus.exit_req : bus.entry_req) ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= 3'd0;
      tok_q <= 3'd0;
      is_exit <= 1'b0;
      bus.occupied <= 8'd0;
      bus.free_count <= 4'(N_SLOTS);
      bus.full <= 1'b0;
      bus.entry_grant <= 1'b0;
      bus.entry_token <= 3'd0;
      bus.entry_reject <= 1'b0;
      bus.exit_ack <= 1'b0;
      bus.exit_location <= 8'd0;
      bus.exit_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pat_q <= pat_nxt;
      tok_q <= tok_nxt;
      is_exit <= is_exit_nxt;
      bus.occupied <= occ_nxt;
      bus.free_count <= fc_nxt;
      bus.full <= fc_nxt == 4'd0;
      bus.entry_grant <= grant_nxt;
      bus.entry_token <= etok_nxt;
      bus.entry_reject <= rej_nxt;
      bus.exit_ack <= ack_nxt;
      bus.exit_location <= loc_nxt;
      bus.exit_err <= err_nxt;
    end
`ifdef PARK_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  logic [FW-1:0] fails;
  logic [TW-1:0] timer;
  logic locked_q;
  assign lock_busy = locked_q;
  assign bus.locked = locked_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      fails <= '0;
      timer <= '0;
      locked_q <= 1'b0;
    end else begin
      if (locked_q) begin
        timer <= timer - 1'b1;
        if (timer == TW'(1)) locked_q <= 1'b0;
      end
      if (ack_nxt)
        fails <= '0;
      else if (err_nxt) begin
        if (fails == FW'(MAX_FAIL - 1)) begin
          fails <= '0;
          locked_q <= 1'b1;
          timer <= TW'(LOCK_CYCLES);
        end else
          fails <= fails + 1'b1;
      end
    end
`else
  logic unused_params;
  assign unused_params = ^{MAX_FAIL, LOCK_CYCLES};
  assign lock_busy = 1'b0;
  assign bus.locked = 1'b0;
`endif
endmodule

// File: tb/tb_park_scheduler.sv
// tb_park_scheduler: directed self-checking bench for park_scheduler
module tb_park_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int lock_len = 0;
  logic r_grant, r_rej, r_ack, r_err, seen;
  logic [2:0] r_tok;
  logic [7:0] r_loc;
  park_scheduler_if bus();
  park_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.locked === 1'b1) lock_len++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit ex, input logic [2:0] tok, input logic [2:0] pat);
    int n;
    @(negedge clk);
    bus.pattern = pat;
    bus.exit_token = tok;
    if (ex) bus.exit_req = 1'b1;
    else bus.entry_req = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.pattern = ~pat;
        bus.exit_token = ~tok;
      end
      seen = bus.entry_grant | bus.entry_reject | bus.exit_ack | bus.exit_err;
    end
    r_grant = bus.entry_grant;
    r_tok = bus.entry_token;
    r_rej = bus.entry_reject;
    r_ack = bus.exit_ack;
    r_loc = bus.exit_location;
    r_err = bus.exit_err;
    bus.entry_req = 1'b0;
    bus.exit_req = 1'b0;
    chk("latency", 32'(n), 2);
  endtask
  initial begin
    int n;
    rst_n = 1'b0;
    bus.entry_req = 1'b0;
    bus.exit_req = 1'b0;
    bus.exit_token = 3'd0;
    bus.pattern = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_occ", 32'(bus.occupied), 0);
    chk("rst_fc", 32'(bus.free_count), 8);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_grant", 32'(bus.entry_grant), 0);
    chk("rst_tok", 32'(bus.entry_token), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    rst_n = 1'b1;
    txn(0, 3'd0, 3'b101);
    chk("e1_grant", 32'(r_grant), 1);
    chk("e1_tok", 32'(r_tok), 5);
    @(negedge clk);
    chk("e1_tok_clr", 32'(bus.entry_token), 0);
    chk("e1_grant_clr", 32'(bus.entry_grant), 0);
    txn(0, 3'd0, 3'b101);
    chk("e2_tok", 32'(r_tok), 4);
    txn(0, 3'd0, 3'b101);
    chk("e3_tok", 32'(r_tok), 7);
    chk("t1_occ", 32'(bus.occupied), 8'h07);
    chk("t1_fc", 32'(bus.free_count), 5);
    txn(1, 3'd4, 3'b101);
    chk("x1_ack", 32'(r_ack), 1);
    chk("x1_loc", 32'(r_loc), 8'h02);
    chk("x1_occ", 32'(bus.occupied), 8'h05);
    chk("x1_fc", 32'(bus.free_count), 6);
    txn(0, 3'd0, 3'b101);
    chk("e4_grant", 32'(r_grant), 1);
    chk("e4_tok", 32'(r_tok), 4);
    for (int i = 3; i < 8; i++) begin
      txn(0, 3'd0, 3'd0);
      chk("fill_tok", 32'(r_tok), 32'(i));
    end
    chk("fill_occ", 32'(bus.occupied), 8'hFF);
    chk("fill_fc", 32'(bus.free_count), 0);
    chk("fill_full", 32'(bus.full), 1);
    txn(0, 3'd0, 3'd0);
    chk("rej", 32'(r_rej), 1);
    chk("rej_grant", 32'(r_grant), 0);
    chk("rej_occ", 32'(bus.occupied), 8'hFF);
    @(negedge clk);
    bus.pattern = 3'd0;
    bus.exit_token = 3'd2;
    bus.exit_req = 1'b1;
    bus.entry_req = 1'b1;
    n = 0;
    while (!(bus.exit_ack | bus.exit_err | bus.entry_grant | bus.entry_reject) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("both_ack", 32'(bus.exit_ack), 1);
    chk("both_loc", 32'(bus.exit_location), 8'h04);
    chk("both_no_grant", 32'(bus.entry_grant), 0);
    bus.exit_req = 1'b0;
    bus.pattern = 3'b110;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.entry_grant | bus.entry_reject) && n < 8);
    chk("both_grant", 32'(bus.entry_grant), 1);
    chk("both_tok", 32'(bus.entry_token), 4);
    chk("both_occ", 32'(bus.occupied), 8'hFF);
    bus.entry_req = 1'b0;
    txn(1, 3'd5, 3'd3);
    chk("x6_ack", 32'(r_ack), 1);
    chk("x6_loc", 32'(r_loc), 8'h40);
    chk("x6_occ", 32'(bus.occupied), 8'hBF);
    chk("x6_fc", 32'(bus.free_count), 1);
    txn(1, 3'd5, 3'd3);
    chk("bad_err", 32'(r_err), 1);
    chk("bad_ack", 32'(r_ack), 0);
    chk("bad_loc", 32'(r_loc), 0);
    chk("bad_occ", 32'(bus.occupied), 8'hBF);
    @(negedge clk);
    bus.exit_token = 3'd0;
    bus.pattern = 3'd0;
    bus.exit_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    bus.exit_req = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      seen = seen | bus.exit_ack | bus.exit_err | bus.entry_grant | bus.entry_reject;
      @(negedge clk);
    end
    chk("rst_mid_pulse", 32'(seen), 0);
    chk("rst_mid_occ", 32'(bus.occupied), 0);
    chk("rst_mid_fc", 32'(bus.free_count), 8);
    chk("rst_mid_full", 32'(bus.full), 0);
    txn(0, 3'd0, 3'd0);
    chk("post_rst_tok", 32'(r_tok), 0);
    chk("post_rst_occ", 32'(bus.occupied), 8'h01);
    for (int i = 0; i < 3; i++) begin
      txn(1, 3'd5, 3'd0);
      chk("lk_err", 32'(r_err), 1);
    end
`ifdef PARK_LOCKOUT_EN
    chk("lk_on", 32'(bus.locked), 1);
    txn(0, 3'd0, 3'd0);
    chk("lk_entry_grant", 32'(r_grant), 1);
    chk("lk_entry_tok", 32'(r_tok), 1);
    chk("lk_still", 32'(bus.locked), 1);
    @(negedge clk);
    bus.exit_token = 3'd0;
    bus.pattern = 3'd0;
    bus.exit_req = 1'b1;
    seen = 1'b0;
    n = 0;
    while (bus.locked && n < 40) begin
      seen = seen | bus.exit_ack | bus.exit_err;
      @(negedge clk);
      n++;
    end
    chk("lk_ignored", 32'(seen), 0);
    chk("lk_len", 32'(lock_len), 16);
    n = 0;
    while (!(bus.exit_ack | bus.exit_err) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("lk_after_ack", 32'(bus.exit_ack), 1);
    chk("lk_after_loc", 32'(bus.exit_location), 8'h01);
    bus.exit_req = 1'b0;
`else
    chk("nolk_locked", 32'(bus.locked), 0);
    txn(1, 3'd0, 3'd0);
    chk("nolk_ack", 32'(r_ack), 1);
    chk("nolk_loc", 32'(r_loc), 8'h01);
    chk("nolk_occ", 32'(bus.occupied), 0);
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
